gray_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one Gray-code transmit lane among NREQ requesters on the G_CLK_TX domain.
- Arbitrates pending requests and captures the winner's binary word.
- Converts the word to Gray code.
- Sequences a framed serial transmission: start bit, Gray bits MSB first, stop bit.
- Sits between the requesting TX sources and the serial line driver.

---
 rtl/gray_tx_pkg.sv | 29 ++
 rtl/gray_rr_arb.sv | 34 +++
 rtl/gray_tx_scheduler.sv | 171 +++++++++++++++++
 tb/tb_gray_tx_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_tx_pkg.sv
// rtl/gray_tx_pkg.sv - shared types, frame constants and Gray helper for gray_tx_scheduler
//
// Optional feature macro: GRAY_TX_PARITY_EN (adds an even-parity bit after the data bits).
package gray_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Non-data bits per frame: start + stop, plus parity when enabled.
`ifdef GRAY_TX_PARITY_EN
    localparam int FRAME_OVERHEAD = 3;
`else
    localparam int FRAME_OVERHEAD = 2;
`endif

    // Widest word the helper handles; callers zero-extend and slice back.
    localparam int GRAY_MAX_W = 16;

    // Zero-extension keeps the result exact for any narrower width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] d);
        return d ^ (d >> 1);
    endfunction

endpackage

// File: rtl/gray_rr_arb.sv
// rtl/gray_rr_arb.sv - combinational round-robin winner search starting after the pointer
//
// Ports:
//   i_req   - pending request per requester
//   i_ptr   - last granted index; search begins at i_ptr+1 and wraps at NREQ
//   o_win   - index of the winning requester (0 when none)
//   o_valid - at least one request is pending
module gray_rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_win,
    output logic             o_valid
);

    logic [IDX_W-1:0] w_k;

    // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        o_valid = 1'b0;
        o_win   = '0;
        w_k     = '0;
        for (int i = NREQ; i >= 1; i--) begin
            w_k = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (i_req[w_k]) begin
                o_valid = 1'b1;
                o_win   = w_k;
            end
        end
    end

endmodule

// File: rtl/gray_tx_scheduler.sv
// rtl/gray_tx_scheduler.sv - round-robin scheduler driving one framed Gray-code serial lane
//
// Optional feature macro: GRAY_TX_PARITY_EN (even-parity bit between data and stop).
// Ports:
//   G_CLK_TX   - transmit clock, rising edge
//   rst        - asynchronous active-low reset; aborts any frame in progress
//   req_i      - level request per requester, held until granted
//   data_i     - binary words, requester k at [k*WIDTH +: WIDTH]
//   gnt_o      - one-hot pulse during the start-bit cycle of the winner's frame
//   owner_o    - index of the current or last granted requester
//   busy_o     - frame in progress
//   tx_o       - serial line, idles high; start 0, Gray bits MSB first, [parity], stop 1
//   tx_valid_o - high for every frame bit
module gray_tx_scheduler
    import gray_tx_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                     G_CLK_TX,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_i,
    input  logic [NREQ*WIDTH-1:0]    data_i,
    output logic [NREQ-1:0]          gnt_o,
    output logic [$clog2(NREQ)-1:0]  owner_o,
    output logic                     busy_o,
    output logic                     tx_o,
    output logic                     tx_valid_o
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state, w_state_n;
    logic [WIDTH-1:0]   r_shift, w_shift_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [IDX_W-1:0]   r_ptr, w_ptr_n;
    logic [IDX_W-1:0]   r_owner, w_owner_n;
    logic [NREQ-1:0]    r_gnt, w_gnt_n;
    logic               r_busy, w_busy_n;
    logic               r_tx, w_tx_n;
    logic               r_tx_valid, w_tx_valid_n;
`ifdef GRAY_TX_PARITY_EN
    logic               r_par, w_par_n;
`endif

    logic [IDX_W-1:0]   w_win;
    logic               w_win_valid;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   w_gray;

    gray_rr_arb #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_win   (w_win),
        .o_valid (w_win_valid)
    );

    assign w_word = data_i[w_win*WIDTH +: WIDTH];
    assign w_gray = WIDTH'(bin2gray(GRAY_MAX_W'(w_word)));

    always_ff @(posedge G_CLK_TX or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_ptr      <= IDX_W'(NREQ - 1);
            r_owner    <= '0;
            r_gnt      <= '0;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_valid <= 1'b0;
`ifdef GRAY_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_n;
            r_shift    <= w_shift_n;
            r_cnt      <= w_cnt_n;
            r_ptr      <= w_ptr_n;
            r_owner    <= w_owner_n;
            r_gnt      <= w_gnt_n;
            r_busy     <= w_busy_n;
            r_tx       <= w_tx_n;
            r_tx_valid <= w_tx_valid_n;
`ifdef GRAY_TX_PARITY_EN
            r_par      <= w_par_n;
`endif
        end
    end

    // Outputs are registered: each branch computes the line value for the state being entered.
    always_comb begin
        w_state_n    = r_state;
        w_shift_n    = r_shift;
        w_cnt_n      = r_cnt;
        w_ptr_n      = r_ptr;
        w_owner_n    = r_owner;
        w_gnt_n      = '0;
        w_busy_n     = r_busy;
        w_tx_n       = r_tx;
        w_tx_valid_n = r_tx_valid;
`ifdef GRAY_TX_PARITY_EN
        w_par_n      = r_par;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_n        = ST_START;
                    w_shift_n        = w_gray;
                    w_gnt_n[w_win]   = 1'b1;
                    w_owner_n        = w_win;
                    w_ptr_n          = w_win;
                    w_busy_n         = 1'b1;
                    w_tx_n           = 1'b0;
                    w_tx_valid_n     = 1'b1;
`ifdef GRAY_TX_PARITY_EN
                    w_par_n          = ^w_gray;
`endif
                end
            end
            ST_START: begin
                w_state_n = ST_DATA;
                w_tx_n    = r_shift[WIDTH-1];
                w_shift_n = {r_shift[WIDTH-2:0], 1'b0};
                w_cnt_n   = '0;
            end
            ST_DATA: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
`ifdef GRAY_TX_PARITY_EN
                    w_state_n = ST_PARITY;
                    w_tx_n    = r_par;
`else
                    w_state_n = ST_STOP;
                    w_tx_n    = 1'b1;
`endif
                end else begin
                    w_tx_n    = r_shift[WIDTH-1];
                    w_shift_n = {r_shift[WIDTH-2:0], 1'b0};
                    w_cnt_n   = r_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                w_state_n = ST_STOP;
                w_tx_n    = 1'b1;
            end
            ST_STOP: begin
                w_state_n    = ST_IDLE;
                w_tx_n       = 1'b1;
                w_tx_valid_n = 1'b0;
                w_busy_n     = 1'b0;
            end
            default: begin
                w_state_n    = ST_IDLE;
                w_tx_n       = 1'b1;
                w_tx_valid_n = 1'b0;
                w_busy_n     = 1'b0;
            end
        endcase
    end

    assign gnt_o      = r_gnt;
    assign owner_o    = r_owner;
    assign busy_o     = r_busy;
    assign tx_o       = r_tx;
    assign tx_valid_o = r_tx_valid;

endmodule

// File: tb/tb_gray_tx_scheduler.sv
// tb/tb_gray_tx_scheduler.sv - scoreboard bench for gray_tx_scheduler
module tb_gray_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDX_W = $clog2(NREQ);
`ifdef GRAY_TX_PARITY_EN
    localparam int PERIOD = WIDTH + 4;
`else
    localparam int PERIOD = WIDTH + 3;
`endif
    localparam int DRAIN_LIM = 2000;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_i;
    logic [NREQ*WIDTH-1:0]   data_i;
    logic [NREQ-1:0]         gnt_o;
    logic [IDX_W-1:0]        owner_o;
    logic                    busy_o;
    logic                    tx_o;
    logic                    tx_valid_o;

    gray_tx_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .G_CLK_TX   (clk),
        .rst        (rst),
        .req_i      (req_i),
        .data_i     (data_i),
        .gnt_o      (gnt_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o),
        .tx_o       (tx_o),
        .tx_valid_o (tx_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        bit               b2b;
    } exp_t;

    exp_t   q[$];
    int     model_ptr;
    bit     mon_en = 1'b0;
    bit     hold   = 1'b0;
    int     n_cmp  = 0;
    int     n_bad  = 0;
    int     cyc    = 0;
    int     last_gnt_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first pending requester after the last winner, wrapping.
    function automatic int next_winner(input logic [NREQ-1:0] mask, input int p);
        for (int i = 1; i <= NREQ; i++) begin
            if (mask[(p + i) % NREQ]) return (p + i) % NREQ;
        end
        return -1;
    endfunction

    // Requesters release their line once they see their grant.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!hold) req_i = req_i & ~gnt_o;
        end
    end

    task automatic check_frame();
        exp_t e;
        logic [WIDTH-1:0] g;
        if (q.size() == 0) begin
            chk("unexpected_gnt", 32'(gnt_o), 32'd0);
            return;
        end
        e = q.pop_front();
        g = e.data ^ (e.data >> 1);
        chk("gnt_onehot", 32'(gnt_o), 32'(1) << e.idx);
        chk("owner", 32'(owner_o), 32'(e.idx));
        chk("start_tx", 32'(tx_o), 32'd0);
        chk("start_valid", 32'(tx_valid_o), 32'd1);
        chk("start_busy", 32'(busy_o), 32'd1);
        if (e.b2b) chk("gnt_period", 32'(cyc - last_gnt_cyc), 32'(PERIOD));
        last_gnt_cyc = cyc;
        for (int j = WIDTH - 1; j >= 0; j--) begin
            @(negedge clk);
            chk("data_bit", 32'(tx_o), 32'(g[j]));
            chk("data_valid", 32'(tx_valid_o), 32'd1);
            chk("data_gnt_low", 32'(gnt_o), 32'd0);
            chk("data_busy", 32'(busy_o), 32'd1);
        end
`ifdef GRAY_TX_PARITY_EN
        @(negedge clk);
        chk("parity_bit", 32'(tx_o), 32'(^g));
        chk("parity_valid", 32'(tx_valid_o), 32'd1);
`endif
        @(negedge clk);
        chk("stop_tx", 32'(tx_o), 32'd1);
        chk("stop_valid", 32'(tx_valid_o), 32'd1);
        chk("stop_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("idle_tx", 32'(tx_o), 32'd1);
        chk("idle_valid", 32'(tx_valid_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_owner_hold", 32'(owner_o), 32'(e.idx));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst && gnt_o != '0) check_frame();
        end
    end

    task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] d);
        logic [NREQ-1:0] m;
        int k;
        bit first;
        m = mask;
        first = 1'b1;
        while (m != '0) begin
            k = next_winner(m, model_ptr);
            q.push_back('{idx: k, data: d[k*WIDTH +: WIDTH], b2b: !first});
            model_ptr = k;
            m[k] = 1'b0;
            first = 1'b0;
        end
        @(negedge clk);
        data_i = d;
        req_i  = mask;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || busy_o || req_i != '0) && t < DRAIN_LIM) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (t >= DRAIN_LIM) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d frames still pending after %0d cycles", q.size(), t);
            q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [NREQ*WIDTH-1:0] rand_data();
        logic [NREQ*WIDTH-1:0] d;
        for (int k = 0; k < NREQ; k++) d[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ*WIDTH-1:0] d;
        logic [WIDTH-1:0] dir_vals [4];
        int cnt, t;

        rst    = 1'b0;
        req_i  = '0;
        data_i = '0;
        model_ptr = NREQ - 1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single-request frames with the Gray patterns of interest.
        dir_vals[0] = WIDTH'(4'b1011);
        dir_vals[1] = WIDTH'(4'b1111);
        dir_vals[2] = WIDTH'(4'b0000);
        dir_vals[3] = WIDTH'(4'b0110);
        for (int i = 0; i < 4; i++) begin
            d = rand_data();
            d[0 +: WIDTH] = dir_vals[i];
            run_batch(NREQ'(1), d);
            drain();
        end

        // All requesters held high: five grants in rotation, back to back.
        d = rand_data();
        hold = 1'b1;
        for (int n = 0; n < 5; n++) begin
            model_ptr = next_winner('1, model_ptr);
            q.push_back('{idx: model_ptr, data: d[model_ptr*WIDTH +: WIDTH], b2b: (n != 0)});
        end
        @(negedge clk);
        data_i = d;
        req_i  = '1;
        cnt = 0;
        t = 0;
        while (cnt < 5 && t < 200) begin
            @(posedge clk);
            #1;
            if (gnt_o != '0) cnt++;
            t++;
        end
        req_i = '0;
        hold  = 1'b0;
        drain();

        // Reset during the second data bit of a frame from requester 2.
        mon_en = 1'b0;
        d = rand_data();
        d[2*WIDTH +: WIDTH] = WIDTH'(4'b1111);
        @(negedge clk);
        data_i = d;
        req_i  = NREQ'(4);
        t = 0;
        while (gnt_o == '0 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("pre_rst_owner", 32'(owner_o), 32'd2);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst   = 1'b0;
        req_i = '0;
        #1;
        chk("midrst_tx", 32'(tx_o), 32'd1);
        chk("midrst_valid", 32'(tx_valid_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_gnt", 32'(gnt_o), 32'd0);
        chk("midrst_owner", 32'(owner_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_ptr = NREQ - 1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_tx_idle", 32'(tx_o), 32'd1);
            chk("post_rst_busy", 32'(busy_o), 32'd0);
        end
        mon_en = 1'b1;
        run_batch(NREQ'(4'b1010), rand_data());
        drain();

        // Random request sets.
        for (int b = 0; b < 25; b++) begin
            run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)), rand_data());
            drain();
        end

        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
